moore_seq_detect_param: RTL and testbench

MOORE_SEQ_DETECT_PARAM -- requirements
Module: moore_seq_detect_param

---
 rtl/moore_seq_detect_param.sv | 124 ++++++++++++
 tb/tb_moore_seq_detect_param.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/moore_seq_detect_param.sv
// Parameterised Moore sequence detector with a runtime-loadable pattern and optional match counter.
// Define MOORE_SEQ_CNT_EN to build the saturating match counter; otherwise match_cnt is tied to 0.
module moore_seq_detect_param #(
  parameter int unsigned    N       = 4,
  parameter logic [N-1:0]   PATTERN = 4'b1010,
  parameter int unsigned    OVERLAP = 1,
  parameter int unsigned    CNT_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             a,
  input  logic             in_valid,
  input  logic             pat_load,
  input  logic [N-1:0]     pat_in,
  input  logic             cnt_clr,
  output logic             d,
  output logic [CNT_W-1:0] match_cnt
);

  localparam int unsigned   KW    = $clog2(N + 1);
  localparam logic [KW-1:0] KFull = KW'(N);

  logic [N-1:0]  pat_q, pat_d;
  logic [N-1:0]  hist_q, hist_d;
  logic [KW-1:0] vcnt_q, vcnt_d;
  logic [KW-1:0] k_cur, k_nxt;
  logic          d_q, d_d;
  logic          hit;

  // Longest j <= v such that the newest j history bits (hist[0] newest) equal the
  // top j pattern bits, oldest bit aligned with pattern MSB.
  function automatic logic [KW-1:0] calc_k(input logic [N-1:0]  h,
                                           input logic [KW-1:0] v,
                                           input logic [N-1:0]  p);
    logic [KW-1:0] k;
    logic [N-1:0]  mask;
    k = '0;
    for (int j = 1; j <= int'(N); j++) begin
      mask = {N{1'b1}} >> (N - j);
      if ((KW'(j) <= v) && ((h & mask) == (p >> (N - j)))) begin
        k = KW'(j);
      end
    end
    return k;
  endfunction

  assign k_cur = calc_k(hist_q, vcnt_q, pat_q);
  assign k_nxt = calc_k(hist_d, vcnt_d, pat_d);

  always_comb begin
    pat_d  = pat_q;
    hist_d = hist_q;
    vcnt_d = vcnt_q;
    if (pat_load) begin
      pat_d  = pat_in;
      hist_d = '0;
      vcnt_d = '0;
    end else if (in_valid) begin
      if ((OVERLAP == 0) && (k_cur == KFull)) begin
        // Non-overlapping: the bit after a match starts from an empty history.
        hist_d = {{(N-1){1'b0}}, a};
        vcnt_d = KW'(1);
      end else begin
        hist_d = {hist_q[N-2:0], a};
        vcnt_d = (vcnt_q == KFull) ? vcnt_q : vcnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    d_d = d_q;
    hit = 1'b0;
    if (pat_load) begin
      d_d = 1'b0;
    end else if (in_valid) begin
      hit = (k_nxt == KFull);
      d_d = hit;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pat_q  <= PATTERN;
      hist_q <= '0;
      vcnt_q <= '0;
      d_q    <= 1'b0;
    end else begin
      pat_q  <= pat_d;
      hist_q <= hist_d;
      vcnt_q <= vcnt_d;
      d_q    <= d_d;
    end
  end

  assign d = d_q;

`ifdef MOORE_SEQ_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr) begin
      cnt_d = hit ? CNT_W'(1) : '0;
    end else if (hit && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign match_cnt = cnt_q;
`else
  logic unused_cnt_clr;
  assign unused_cnt_clr = cnt_clr;
  assign match_cnt      = '0;
`endif

endmodule

// File: tb/tb_moore_seq_detect_param.sv
// Scoreboard bench for moore_seq_detect_param: three instances (overlap, non-overlap,
// 2-bit counter) driven with directed vectors; a negedge monitor pops expected values.
module tb_moore_seq_detect_param;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] a_v, iv_v, ld_v, clr_v;
  logic [3:0] pin_v;
  logic [2:0] d_v;
  logic [7:0] mc0, mc1;
  logic [1:0] mc2;

`ifdef MOORE_SEQ_CNT_EN
  localparam bit CntEn = 1'b1;
`else
  localparam bit CntEn = 1'b0;
`endif

  always #5 clk = ~clk;

  moore_seq_detect_param u_ov (
    .clk(clk), .reset(rst_n), .a(a_v[0]), .in_valid(iv_v[0]), .pat_load(ld_v[0]),
    .pat_in(pin_v), .cnt_clr(clr_v[0]), .d(d_v[0]), .match_cnt(mc0)
  );

  moore_seq_detect_param #(.OVERLAP(0)) u_no (
    .clk(clk), .reset(rst_n), .a(a_v[1]), .in_valid(iv_v[1]), .pat_load(ld_v[1]),
    .pat_in(pin_v), .cnt_clr(clr_v[1]), .d(d_v[1]), .match_cnt(mc1)
  );

  moore_seq_detect_param #(.CNT_W(2)) u_c2 (
    .clk(clk), .reset(rst_n), .a(a_v[2]), .in_valid(iv_v[2]), .pat_load(ld_v[2]),
    .pat_in(pin_v), .cnt_clr(clr_v[2]), .d(d_v[2]), .match_cnt(mc2)
  );

  typedef struct {
    int   cyc;
    int   du;
    int   tid;
    logic ed;
    int   ecnt;
  } exp_t;

  exp_t sbq[$];
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   tid = 0;
  int   ec[3];

  int sa [15] = '{1, 1, 0, 1, 0, 1, 0, 1, 1, 1, 0, 1, 0, 1, 0};
  int pa0[15] = '{0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 1, 0, 1};
  int pa1[15] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0};
  int sc [8]  = '{1, 1, 0, 0, 1, 1, 0, 0};
  int pc [8]  = '{0, 0, 0, 1, 0, 0, 0, 1};
  int so [7]  = '{1, 0, 0, 1, 0, 1, 0};
  int se [12] = '{1, 0, 1, 0, 1, 0, 1, 0, 1, 0, 1, 0};
  int pe [12] = '{0, 0, 0, 1, 0, 1, 0, 1, 0, 1, 0, 1};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input int du, input int actv, input int expv);
    total++;
    if (actv != expv) begin
      bad++;
      $display("FAIL %s dut%0d cyc%0d: got %0d expected %0d", nm, du, cyc, actv, expv);
    end
  endtask

  function automatic int act_d(input int du);
    case (du)
      0:       return int'(d_v[0]);
      1:       return int'(d_v[1]);
      default: return int'(d_v[2]);
    endcase
  endfunction

  function automatic int act_cnt(input int du);
    case (du)
      0:       return int'(mc0);
      1:       return int'(mc1);
      default: return int'(mc2);
    endcase
  endfunction

  always @(negedge clk) begin
    exp_t e;
    while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
      e = sbq.pop_front();
      if (e.cyc != cyc) begin
        check("sb_late", e.du, e.cyc, cyc);
      end else begin
        check($sformatf("t%0d_d", e.tid), e.du, act_d(e.du), int'(e.ed));
        check($sformatf("t%0d_cnt", e.tid), e.du, act_cnt(e.du), e.ecnt);
      end
    end
  end

  task automatic push(input int du, input logic ed, input int ecv);
    exp_t e;
    e.cyc  = cyc + 1;
    e.du   = du;
    e.tid  = tid;
    e.ed   = ed;
    e.ecnt = CntEn ? ecv : 0;
    sbq.push_back(e);
  endtask

  task automatic drive(input logic [2:0] m, input logic ai, input logic iv, input logic ld,
                       input logic clr, input logic [3:0] pi);
    a_v   = {3{ai}};
    iv_v  = iv ? m : 3'b000;
    ld_v  = ld ? m : 3'b000;
    clr_v = clr ? m : 3'b000;
    pin_v = pi;
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    drive(3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000);
    ec = '{0, 0, 0};
    #3;
    for (int du = 0; du < 3; du++) begin
      check("rst_d", du, act_d(du), 0);
      check("rst_cnt", du, act_cnt(du), 0);
    end
    tick();
    rst_n = 1'b1;
    for (int du = 0; du < 3; du++) push(du, 1'b0, 0);
    tick();

    // Shared stream into overlapping and non-overlapping detectors
    tid = 1;
    for (int i = 0; i < 15; i++) begin
      drive(3'b011, sa[i][0], 1'b1, 1'b0, 1'b0, 4'b0000);
      if (pa0[i] != 0) ec[0]++;
      if (pa1[i] != 0) ec[1]++;
      push(0, pa0[i][0], ec[0]);
      push(1, pa1[i][0], ec[1]);
      tick();
    end

    // 1,0,1 continuing the overlap stream, then asynchronous reset mid-cycle
    tid = 2;
    for (int i = 0; i < 3; i++) begin
      drive(3'b001, (i != 1), 1'b1, 1'b0, 1'b0, 4'b0000);
      if (i == 1) ec[0]++;
      push(0, (i == 1), ec[0]);
      tick();
    end
    drive(3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000);
    #1 rst_n = 1'b0;
    #1;
    for (int du = 0; du < 3; du++) begin
      check("async_d", du, act_d(du), 0);
      check("async_cnt", du, act_cnt(du), 0);
    end
    #1 rst_n = 1'b1;
    ec = '{0, 0, 0};
    tick();
    drive(3'b001, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0000);
    push(0, 1'b0, 0);
    tick();

    // Runtime pattern 1100; load edge carries a=1 that must be ignored
    tid = 3;
    drive(3'b001, 1'b1, 1'b1, 1'b1, 1'b0, 4'b1100);
    push(0, 1'b0, ec[0]);
    tick();
    for (int i = 0; i < 8; i++) begin
      drive(3'b001, sc[i][0], 1'b1, 1'b0, 1'b0, 4'b0000);
      if (pc[i] != 0) ec[0]++;
      push(0, pc[i][0], ec[0]);
      tick();
    end
    drive(3'b001, 1'b1, 1'b1, 1'b1, 1'b0, 4'b1100);
    push(0, 1'b0, ec[0]);
    tick();
    for (int i = 0; i < 7; i++) begin
      drive(3'b001, so[i][0], 1'b1, 1'b0, 1'b0, 4'b0000);
      push(0, 1'b0, ec[0]);
      tick();
    end

    // 1010 with 3-cycle in_valid gaps on the non-overlapping instance
    tid = 4;
    for (int i = 0; i < 4; i++) begin
      drive(3'b010, (i % 2 == 0), 1'b1, 1'b0, 1'b0, 4'b0000);
      if (i == 3) ec[1]++;
      push(1, (i == 3), ec[1]);
      tick();
      for (int j = 0; j < 3; j++) begin
        drive(3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000);
        push(1, (i == 3), ec[1]);
        tick();
      end
    end
    drive(3'b010, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0000);
    push(1, 1'b0, ec[1]);
    tick();

    // Two-bit counter: saturation and cnt_clr interaction
    tid = 5;
    n = 0;
    for (int i = 0; i < 12; i++) begin
      drive(3'b100, se[i][0], 1'b1, 1'b0, 1'b0, 4'b0000);
      if (pe[i] != 0) n++;
      push(2, pe[i][0], (n > 3) ? 3 : n);
      tick();
    end
    drive(3'b100, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0000);
    push(2, 1'b0, 3);
    tick();
    drive(3'b100, 1'b0, 1'b1, 1'b0, 1'b1, 4'b0000);
    push(2, 1'b1, 1);
    tick();
    drive(3'b100, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0000);
    push(2, 1'b1, 0);
    tick();
    drive(3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000);
    push(2, 1'b1, 0);
    tick();

    for (int i = 0; i < 4 && sbq.size() > 0; i++) tick();
    if (sbq.size() > 0) check("sb_drain", 0, sbq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
